// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed, XOR-checksummed
// byte stream and writes little-endian 32-bit words to consecutive
// instruction memory addresses. The CPU is held until a load verifies.
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  // Word count limit widened by one bit so MEM_WORDS up to 65536 compares exactly.
  localparam logic [16:0] LP_MAX_WORDS = 17'(MEM_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_len;
  logic [1:0]            r_idx;
  logic [7:0]            r_csum;
  logic [23:0]           r_word;
  logic [15:0]           r_words;
  logic [ADDR_WIDTH-1:0] r_mem_waddr;
  logic [31:0]           r_mem_wdata;

  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_start_ok;
  logic [15:0]           w_len_full;
  logic [ADDR_WIDTH-1:0] w_word_off;

  assign w_ready    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_xfer     = byte_valid && w_ready;
  // start only counts when no load is in flight.
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERR));
  assign w_len_full = {byte_in, r_len[7:0]};
  assign w_word_off = ADDR_WIDTH'({r_words, 2'b00});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    w_next   = r_state;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_LEN0;
      S_LEN0: begin
        busy = 1'b1;
        if (w_xfer) w_next = S_LEN1;
      end
      S_LEN1: begin
        busy = 1'b1;
        if (w_xfer) begin
          if ({1'b0, w_len_full} > LP_MAX_WORDS) w_next = S_ERR;
          else if (w_len_full == 16'd0)          w_next = S_CSUM;
          else                                   w_next = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (w_xfer && (r_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        w_next = ((r_words + 16'd1) == r_len) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        busy = 1'b1;
        if (w_xfer) w_next = (byte_in == r_csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (w_start_ok) w_next = S_LEN0;
      end
      S_ERR: begin
        error = 1'b1;
        if (w_start_ok) w_next = S_LEN0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte lane assembly, checksum, write port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_words     <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else if (w_start_ok) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        S_LEN0: if (w_xfer) r_len[7:0]  <= byte_in;
        S_LEN1: if (w_xfer) r_len[15:8] <= byte_in;
        S_DATA: if (w_xfer) begin
          r_csum <= r_csum ^ byte_in;
          r_idx  <= r_idx + 2'd1;
          case (r_idx)
            2'd0: r_word[7:0]   <= byte_in;
            2'd1: r_word[15:8]  <= byte_in;
            2'd2: r_word[23:16] <= byte_in;
            default: begin
              // Last lane: present the complete word on the write port for WRITE.
              r_mem_wdata <= {byte_in, r_word};
              r_mem_waddr <= BASE_ADDR + w_word_off;
            end
          endcase
        end
        S_WRITE: r_words <= r_words + 16'd1;
        default: ;
      endcase
    end
  end

  assign byte_ready    = w_ready;
  assign mem_waddr     = r_mem_waddr;
  assign mem_wdata     = r_mem_wdata;
  assign words_written = r_words;

endmodule
